// File: rtl/ball_engine.sv
// ball_engine: Pong ball movement, wall/paddle bounces, miss detection,
// point pulses and serve sequencing. All motion happens on a divided tick.
// Optional build macro SPEEDUP_EN: every fourth paddle hit raises the ball
// speed by one pixel per tick, up to BALL_SPEED_MAX; reset on each serve.
module ball_engine #(
   parameter int SCREEN_WIDTH   = 640,
   parameter int SCREEN_HEIGHT  = 480,
   parameter int PADDLE_HEIGHT  = 60,
   parameter int PADDLE_WIDTH   = 10,
   parameter int PADDLE1_X      = 20,
   parameter int PADDLE2_X      = 610,
   parameter int BALL_SIZE      = 8,
   parameter int BALL_SPEED     = 2,
   parameter int BALL_SPEED_MAX = 6,
   parameter int TICK_DIV       = 1_000_000,
   parameter int SERVE_DELAY    = 60
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [9:0] paddle1_y,
   input  logic [9:0] paddle2_y,
   output logic [9:0] ball_x,
   output logic [9:0] ball_y,
   output logic       serving,
   output logic       hit,
   output logic       point_p1,
   output logic       point_p2
);

   localparam int TICK_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int SERVE_W = (SERVE_DELAY > 0) ? $clog2(SERVE_DELAY + 1) : 1;
   // Speed register is wide enough for the ceiling even when speed-up is off
   localparam int SPD_TOP = (BALL_SPEED_MAX > BALL_SPEED) ? BALL_SPEED_MAX : BALL_SPEED;
   localparam int SPD_W   = $clog2(SPD_TOP + 1);

   localparam logic [10:0] L_X_CTR = 11'((SCREEN_WIDTH - BALL_SIZE) / 2);
   localparam logic [10:0] L_Y_CTR = 11'((SCREEN_HEIGHT - BALL_SIZE) / 2);
   localparam logic [10:0] L_Y_MAX = 11'(SCREEN_HEIGHT - BALL_SIZE);
   localparam logic [10:0] L_F1    = 11'(PADDLE1_X + PADDLE_WIDTH);
   localparam logic [10:0] L_P2X   = 11'(PADDLE2_X);
   localparam logic [10:0] L_BS    = 11'(BALL_SIZE);
   localparam logic [10:0] L_PH    = 11'(PADDLE_HEIGHT);
   localparam logic [10:0] L_W     = 11'(SCREEN_WIDTH);

   localparam logic [TICK_W-1:0]  L_TICK_LAST  = TICK_W'(TICK_DIV - 1);
   localparam logic [SERVE_W-1:0] L_SERVE_LAST = SERVE_W'(SERVE_DELAY);

   typedef enum logic [1:0] {
      S_SERVE  = 2'd0,
      S_PLAY   = 2'd1,
      S_SCORED = 2'd2
   } state_t;

   state_t              r_state;
   state_t              w_state_next;
   logic [TICK_W-1:0]   r_tick_cnt;
   logic                w_tick;
   logic [SERVE_W-1:0]  r_serve_cnt;
   logic [SERVE_W-1:0]  w_serve_cnt_next;
   logic [SERVE_W-1:0]  w_serve_inc;
   logic [9:0]          r_ball_x;
   logic [9:0]          r_ball_y;
   logic [9:0]          w_x_next;
   logic [9:0]          w_y_next;
   logic                r_dx_right;
   logic                r_dy_down;
   logic                w_dx_next;
   logic                w_dy_next;
   logic                r_hit;
   logic                r_point_p1;
   logic                r_point_p2;
   logic                r_serving;
   logic                w_hit_next;
   logic                w_pp1_next;
   logic                w_pp2_next;
   logic                w_serving_next;
   logic                r_pend_p1;
   logic                w_pend_p1_next;
   logic [SPD_W-1:0]    w_speed;

   // 11-bit working copies so position + size + speed never wraps
   logic [10:0] w_x11, w_y11, w_spd11, w_p1_11, w_p2_11;
   logic [10:0] w_y_down, w_y_up, w_x_fwd, w_x_back, w_x_lead, w_x_lead_next;
   logic        w_ov1, w_ov2;

   assign w_x11         = {1'b0, r_ball_x};
   assign w_y11         = {1'b0, r_ball_y};
   assign w_spd11       = 11'(w_speed);
   assign w_p1_11       = {1'b0, paddle1_y};
   assign w_p2_11       = {1'b0, paddle2_y};
   assign w_y_down      = w_y11 + w_spd11;
   assign w_y_up        = w_y11 - w_spd11;
   assign w_x_fwd       = w_x11 + w_spd11;
   assign w_x_back      = w_x11 - w_spd11;
   assign w_x_lead      = w_x11 + L_BS;
   assign w_x_lead_next = w_x_lead + w_spd11;
   assign w_ov1         = (w_y11 + L_BS > w_p1_11) && (w_y11 < w_p1_11 + L_PH);
   assign w_ov2         = (w_y11 + L_BS > w_p2_11) && (w_y11 < w_p2_11 + L_PH);

   assign w_tick      = (r_tick_cnt == L_TICK_LAST);
   assign w_serve_inc = r_serve_cnt + SERVE_W'(1);

`ifdef SPEEDUP_EN
   logic [1:0]       r_hit_cnt;
   logic [SPD_W-1:0] r_speed;

   // Count paddle hits; every wrap of the 2-bit count bumps the speed (saturating)
   always_ff @(posedge clk) begin
      if (reset || (r_state == S_SCORED)) begin
         r_hit_cnt <= 2'd0;
         r_speed   <= SPD_W'(BALL_SPEED);
      end else if (w_hit_next) begin
         r_hit_cnt <= r_hit_cnt + 2'd1;
         if ((r_hit_cnt == 2'd3) && (r_speed < SPD_W'(BALL_SPEED_MAX)))
            r_speed <= r_speed + SPD_W'(1);
      end
   end
   assign w_speed = r_speed;
`else
   assign w_speed = SPD_W'(BALL_SPEED);
`endif

   // Free-running motion tick divider, active in every state
   always_ff @(posedge clk) begin
      if (reset || w_tick)
         r_tick_cnt <= '0;
      else
         r_tick_cnt <= r_tick_cnt + TICK_W'(1);
   end

   // Serve/play/scored sequencing plus the per-tick ball update
   always_comb begin
      w_state_next     = r_state;
      w_serve_cnt_next = r_serve_cnt;
      w_x_next         = r_ball_x;
      w_y_next         = r_ball_y;
      w_dx_next        = r_dx_right;
      w_dy_next        = r_dy_down;
      w_hit_next       = 1'b0;
      w_pp1_next       = 1'b0;
      w_pp2_next       = 1'b0;
      w_pend_p1_next   = r_pend_p1;
      case (r_state)
         S_SERVE: begin
            if (w_tick) begin
               if (w_serve_inc == L_SERVE_LAST) begin
                  w_state_next     = S_PLAY;
                  w_serve_cnt_next = '0;
               end else begin
                  w_serve_cnt_next = w_serve_inc;
               end
            end
         end
         S_PLAY: begin
            if (w_tick) begin
               // Vertical: clamp to the wall and reverse
               if (r_dy_down) begin
                  if (w_y_down >= L_Y_MAX) begin
                     w_y_next  = 10'(L_Y_MAX);
                     w_dy_next = 1'b0;
                  end else begin
                     w_y_next = 10'(w_y_down);
                  end
               end else begin
                  if (w_y11 <= w_spd11) begin
                     w_y_next  = '0;
                     w_dy_next = 1'b1;
                  end else begin
                     w_y_next = 10'(w_y_up);
                  end
               end
               // Horizontal: paddle face bounce, otherwise miss past the edge
               if (!r_dx_right) begin
                  if ((w_x11 >= L_F1) && (w_x_back <= L_F1) && w_ov1) begin
                     w_x_next   = 10'(L_F1);
                     w_dx_next  = 1'b1;
                     w_hit_next = 1'b1;
                  end else if (w_x11 < w_spd11) begin
                     w_state_next   = S_SCORED;
                     w_pend_p1_next = 1'b0;
                  end else begin
                     w_x_next = 10'(w_x_back);
                  end
               end else begin
                  if ((w_x_lead <= L_P2X) && (w_x_lead_next >= L_P2X) && w_ov2) begin
                     w_x_next   = 10'(L_P2X - L_BS);
                     w_dx_next  = 1'b0;
                     w_hit_next = 1'b1;
                  end else if (w_x_lead_next >= L_W) begin
                     w_state_next   = S_SCORED;
                     w_pend_p1_next = 1'b1;
                  end else begin
                     w_x_next = 10'(w_x_fwd);
                  end
               end
            end
         end
         S_SCORED: begin
            // Re-centre and serve toward the side that conceded
            w_state_next     = S_SERVE;
            w_serve_cnt_next = '0;
            w_x_next         = 10'(L_X_CTR);
            w_y_next         = 10'(L_Y_CTR);
            w_dy_next        = 1'b1;
            w_dx_next        = r_pend_p1;
            w_pp1_next       = r_pend_p1;
            w_pp2_next       = !r_pend_p1;
         end
         default: begin
            w_state_next = S_SERVE;
         end
      endcase
      w_serving_next = (w_state_next == S_SERVE);
   end

   // FSM state register
   always_ff @(posedge clk) begin
      if (reset)
         r_state <= S_SERVE;
      else
         r_state <= w_state_next;
   end

   // Registered ball position, direction, serve count and output pulses
   always_ff @(posedge clk) begin
      if (reset) begin
         r_ball_x    <= 10'(L_X_CTR);
         r_ball_y    <= 10'(L_Y_CTR);
         r_dx_right  <= 1'b1;
         r_dy_down   <= 1'b1;
         r_serve_cnt <= '0;
         r_hit       <= 1'b0;
         r_point_p1  <= 1'b0;
         r_point_p2  <= 1'b0;
         r_serving   <= 1'b1;
         r_pend_p1   <= 1'b0;
      end else begin
         r_ball_x    <= w_x_next;
         r_ball_y    <= w_y_next;
         r_dx_right  <= w_dx_next;
         r_dy_down   <= w_dy_next;
         r_serve_cnt <= w_serve_cnt_next;
         r_hit       <= w_hit_next;
         r_point_p1  <= w_pp1_next;
         r_point_p2  <= w_pp2_next;
         r_serving   <= w_serving_next;
         r_pend_p1   <= w_pend_p1_next;
      end
   end

   assign ball_x   = r_ball_x;
   assign ball_y   = r_ball_y;
   assign serving  = r_serving;
   assign hit      = r_hit;
   assign point_p1 = r_point_p1;
   assign point_p2 = r_point_p2;

endmodule

// File: tb/tb_ball_engine.sv
// Testbench for ball_engine: constant vectors for the serve/launch timeline,
// hand sequences for wall, paddle hit, misses, mid-play reset and (when
// SPEEDUP_EN is defined) speed-up, plus randomized paddles checked every
// cycle against a tick-level behavioural model of the ball.
module tb_ball_engine;
   localparam int TDIV  = 4;
   localparam int SDLY  = 2;
   localparam int BSPD  = 2;
   localparam int BMAX  = 6;
   localparam int BS    = 8;
   localparam int PH    = 60;
   localparam int SW    = 640;
   localparam int Y_MAX = 480 - BS;
   localparam int F1    = 20 + 10;
   localparam int P2X   = 610;
   localparam int XC    = (640 - BS) / 2;
   localparam int YC    = (480 - BS) / 2;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [9:0] paddle1_y = '0;
   logic [9:0] paddle2_y = '0;
   logic [9:0] ball_x, ball_y;
   logic       serving, hit, point_p1, point_p2;

   always #5 clk = ~clk;

   ball_engine #(.TICK_DIV(TDIV), .SERVE_DELAY(SDLY)) dut (
      .clk(clk), .reset(reset), .paddle1_y(paddle1_y), .paddle2_y(paddle2_y),
      .ball_x(ball_x), .ball_y(ball_y), .serving(serving), .hit(hit),
      .point_p1(point_p1), .point_p2(point_p2)
   );

   typedef struct {
      logic rst;
      int   p1;
      int   p2;
      int   n;
      int   ex;
      int   ey;
      logic esrv;
   } vec_t;
   vec_t vecs[8];

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;

   // Behavioural model: signed direction, countdown serve, pending point code
   int   m_x, m_y, m_sx, m_sy, m_spd, m_hits, m_serve_left, m_pending, m_since;
   logic m_serving, m_hit, m_pp1, m_pp2;

   function automatic int clamp10(input int v);
      if (v < 0) return 0;
      if (v > 1023) return 1023;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
   endtask

   task automatic model_reset();
      m_x = XC; m_y = YC; m_sx = 1; m_sy = 1; m_spd = BSPD; m_hits = 0;
      m_serve_left = SDLY; m_pending = 0; m_since = 0;
      m_serving = 1'b1; m_hit = 1'b0; m_pp1 = 1'b0; m_pp2 = 1'b0;
   endtask

   task automatic model_edge(input logic rst, input int p1, input int p2);
      bit tick, ov1, ov2;
      int nx, ny;
      if (rst) begin
         model_reset();
         return;
      end
      m_hit = 1'b0; m_pp1 = 1'b0; m_pp2 = 1'b0;
      m_since++;
      tick = ((m_since % TDIV) == 0);
      if (m_pending != 0) begin
         m_pp1 = (m_pending == 1);
         m_pp2 = (m_pending == 2);
         m_sx = (m_pending == 1) ? 1 : -1;
         m_sy = 1; m_x = XC; m_y = YC;
         m_serving = 1'b1; m_serve_left = SDLY; m_pending = 0;
         m_spd = BSPD; m_hits = 0;
         return;
      end
      if (m_serving) begin
         if (tick) begin
            m_serve_left--;
            if (m_serve_left == 0) m_serving = 1'b0;
         end
         return;
      end
      if (!tick) return;
      ov1 = (m_y + BS > p1) && (m_y < p1 + PH);
      ov2 = (m_y + BS > p2) && (m_y < p2 + PH);
      if (m_sy > 0) begin
         if (m_y + m_spd >= Y_MAX) begin ny = Y_MAX; m_sy = -1; end
         else ny = m_y + m_spd;
      end else begin
         if (m_y <= m_spd) begin ny = 0; m_sy = 1; end
         else ny = m_y - m_spd;
      end
      nx = m_x;
      if (m_sx < 0) begin
         if (m_x >= F1 && m_x - m_spd <= F1 && ov1) begin nx = F1; m_sx = 1; m_hit = 1'b1; end
         else if (m_x < m_spd) m_pending = 2;
         else nx = m_x - m_spd;
      end else begin
         if (m_x + BS <= P2X && m_x + BS + m_spd >= P2X && ov2) begin
            nx = P2X - BS; m_sx = -1; m_hit = 1'b1;
         end else if (m_x + BS + m_spd >= SW) m_pending = 1;
         else nx = m_x + m_spd;
      end
`ifdef SPEEDUP_EN
      if (m_hit) begin
         m_hits++;
         if ((m_hits % 4) == 0 && m_spd < BMAX) m_spd++;
      end
`endif
      m_x = nx;
      m_y = ny;
   endtask

   task automatic compare_all();
      logic [22:0] got, exp;
      got = {ball_x, ball_y, serving, hit, point_p1, point_p2};
      exp = {10'(m_x), 10'(m_y), m_serving, m_hit, m_pp1, m_pp2};
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL model cycle %0d: got x=%0d y=%0d srv=%0b hit=%0b p1=%0b p2=%0b, expected x=%0d y=%0d srv=%0b hit=%0b p1=%0b p2=%0b",
                    cyc, ball_x, ball_y, serving, hit, point_p1, point_p2,
                    m_x, m_y, m_serving, m_hit, m_pp1, m_pp2);
   endtask

   task automatic step_cycle();
      @(posedge clk);
      model_edge(reset, int'(paddle1_y), int'(paddle2_y));
      @(negedge clk);
      cyc++;
      compare_all();
   endtask

   initial begin
      int guard;
      int nhits;
      int x0;
      int d;
      vecs[0] = '{1'b1, 0, 0, 1, 316, 236, 1'b1};
      vecs[1] = '{1'b0, 0, 0, 4, 316, 236, 1'b1};
      vecs[2] = '{1'b0, 0, 0, 3, 316, 236, 1'b1};
      vecs[3] = '{1'b0, 0, 0, 1, 316, 236, 1'b0};
      vecs[4] = '{1'b0, 0, 0, 3, 316, 236, 1'b0};
      vecs[5] = '{1'b0, 0, 0, 1, 318, 238, 1'b0};
      vecs[6] = '{1'b0, 0, 0, 4, 320, 240, 1'b0};
      vecs[7] = '{1'b0, 0, 0, 4, 322, 242, 1'b0};

      for (int i = 0; i < 8; i++) begin
         reset = vecs[i].rst;
         paddle1_y = 10'(vecs[i].p1);
         paddle2_y = 10'(vecs[i].p2);
         repeat (vecs[i].n) step_cycle();
         check($sformatf("vec%0d_x", i), ball_x, vecs[i].ex);
         check($sformatf("vec%0d_y", i), ball_y, vecs[i].ey);
         check($sformatf("vec%0d_serving", i), serving, vecs[i].esrv);
      end

      // Bottom wall, then right paddle hit
      paddle1_y = 10'd0; paddle2_y = 10'd400;
      guard = 0;
      while (ball_y !== 10'd472 && guard < 2000) begin step_cycle(); guard++; end
      check("wall_reached_y", ball_y, 472);
      check("wall_no_hit", hit, 0);
      repeat (TDIV) step_cycle();
      check("wall_next_y", ball_y, 470);
      guard = 0;
      while (hit !== 1'b1 && guard < 2000) begin step_cycle(); guard++; end
      check("hit_pulse", hit, 1);
      check("hit_x", ball_x, 602);
      step_cycle();
      check("hit_one_cycle", hit, 0);
      repeat (TDIV - 1) step_cycle();
      check("after_hit_x", ball_x, 600);

      // Left miss -> point_p2, relaunch to the left
      paddle1_y = 10'd1023;
      guard = 0;
      while (point_p2 !== 1'b1 && guard < 3000) begin step_cycle(); guard++; end
      check("p2_pulse", point_p2, 1);
      check("p2_no_p1", point_p1, 0);
      check("p2_centre_x", ball_x, 316);
      check("p2_centre_y", ball_y, 236);
      check("p2_serving", serving, 1);
      step_cycle();
      check("p2_one_cycle", point_p2, 0);
      guard = 0;
      while (ball_x === 10'd316 && guard < 100) begin step_cycle(); guard++; end
      check("p2_launch_x", ball_x, 314);

      // Left paddle follows the ball, right paddle out of reach -> point_p1
      paddle2_y = 10'd1023;
      guard = 0;
      while (point_p1 !== 1'b1 && guard < 6000) begin
         paddle1_y = 10'(clamp10(m_y - 20));
         step_cycle();
         guard++;
      end
      check("p1_pulse", point_p1, 1);
      check("p1_centre_x", ball_x, 316);
      check("p1_centre_y", ball_y, 236);
      check("p1_serving", serving, 1);
      guard = 0;
      while (ball_x === 10'd316 && guard < 100) begin step_cycle(); guard++; end
      check("p1_launch_x", ball_x, 318);

      // Reset in the middle of play
      repeat (3 * TDIV + 1) step_cycle();
      reset = 1'b1;
      step_cycle();
      reset = 1'b0;
      check("rst_x", ball_x, 316);
      check("rst_y", ball_y, 236);
      check("rst_serving", serving, 1);
      check("rst_pulses", {hit, point_p1, point_p2}, 0);
      repeat (2 * TDIV - 1) step_cycle();
      check("rst_serve_hold", serving, 1);
      check("rst_serve_hold_x", ball_x, 316);
      step_cycle();
      check("rst_serve_done", serving, 0);
      repeat (TDIV) step_cycle();
      check("rst_launch_x", ball_x, 318);
      check("rst_launch_y", ball_y, 238);

      // Randomized paddles, mostly near the ball, with occasional resets
      for (int i = 0; i < 8000; i++) begin
         reset = ($urandom_range(0, 1499) == 0);
         if ($urandom_range(0, 3) == 0) paddle1_y = 10'($urandom_range(0, 1023));
         else paddle1_y = 10'(clamp10(m_y - 59 + int'($urandom_range(0, 66))));
         if ($urandom_range(0, 3) == 0) paddle2_y = 10'($urandom_range(0, 1023));
         else paddle2_y = 10'(clamp10(m_y - 59 + int'($urandom_range(0, 66))));
         step_cycle();
      end
      reset = 1'b0;

`ifdef SPEEDUP_EN
      // Four consecutive hits raise the step to 3; a new serve restores 2
      reset = 1'b1;
      step_cycle();
      reset = 1'b0;
      nhits = 0;
      guard = 0;
      while (nhits < 4 && guard < 12000) begin
         paddle1_y = 10'(clamp10(m_y - 20));
         paddle2_y = 10'(clamp10(m_y - 20));
         step_cycle();
         if (hit === 1'b1) nhits++;
         guard++;
      end
      check("spd_hits", nhits, 4);
      x0 = int'(ball_x);
      repeat (TDIV) step_cycle();
      d = int'(ball_x) - x0;
      if (d < 0) d = -d;
      check("spd_step_fast", d, 3);
      paddle1_y = 10'd1023; paddle2_y = 10'd1023;
      guard = 0;
      while (serving !== 1'b1 && guard < 4000) begin step_cycle(); guard++; end
      check("spd_serve", serving, 1);
      guard = 0;
      while (ball_x === 10'd316 && guard < 100) begin step_cycle(); guard++; end
      d = int'(ball_x) - 316;
      if (d < 0) d = -d;
      check("spd_step_reset", d, 2);
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
